// File: rtl/vend_fsm_param_if.sv
// Coin-acceptor / dispenser bundle for vend_fsm_param.
// master = coin front end + dispenser/hopper side, slave = controller.
// The cancel wire exists only when VEND_REFUND_EN is defined.
interface vend_fsm_param_if #(
    parameter int CREDIT_W = 5
);
    logic [2:0]          coin;
`ifdef VEND_REFUND_EN
    logic                cancel;
`endif
    logic                coin_rdy;
    logic                vend;
    logic                chg_pulse;
    logic [CREDIT_W-1:0] credit;

    modport master (
        output coin,
`ifdef VEND_REFUND_EN
        output cancel,
`endif
        input  coin_rdy,
        input  vend,
        input  chg_pulse,
        input  credit
    );

    modport slave (
        input  coin,
`ifdef VEND_REFUND_EN
        input  cancel,
`endif
        output coin_rdy,
        output vend,
        output chg_pulse,
        output credit
    );
endinterface

// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: sums one-hot coin strobes into credit,
// pulses vend once credit reaches PRICE, then pays change one unit per cycle.
// Optional feature macro: VEND_REFUND_EN (cancel in COLLECT refunds credit).
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | credit = 0, coins accepted
// COLLECT | 0 < credit < PRICE, coins accepted
// VEND    | one-cycle dispense, credit shows the total paid
// CHANGE  | one chg_pulse per cycle, credit = units still owed
module vend_fsm_param #(
    parameter int PRICE     = 5,
    parameter int COIN0_VAL = 1,
    parameter int COIN1_VAL = 2,
    parameter int COIN2_VAL = 10,
    parameter int CREDIT_W  = 5
) (
    input  logic               sys_clk,
    input  logic               rst,
    vend_fsm_param_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_CHANGE  = 2'd3
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] COIN0_C = CREDIT_W'(COIN0_VAL);
    localparam logic [CREDIT_W-1:0] COIN1_C = CREDIT_W'(COIN1_VAL);
    localparam logic [CREDIT_W-1:0] COIN2_C = CREDIT_W'(COIN2_VAL);
    localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);

    state_t              state;
    state_t              state_nxt;
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W-1:0] sum;
    logic                coin_ok;
    logic                cancel_req;

`ifdef VEND_REFUND_EN
    assign cancel_req = bus.cancel;
`else
    assign cancel_req = 1'b0;
`endif

    // Only an exactly-one-hot strobe counts as a coin; anything else is noise.
    always_comb begin
        coin_val = '0;
        coin_ok  = 1'b0;
        case (bus.coin)
            3'b001: begin coin_val = COIN0_C; coin_ok = 1'b1; end
            3'b010: begin coin_val = COIN1_C; coin_ok = 1'b1; end
            3'b100: begin coin_val = COIN2_C; coin_ok = 1'b1; end
            default: ;
        endcase
    end

    assign sum = credit + coin_val;

    // Next-state and next-credit decision.
    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        case (state)
            S_IDLE, S_COLLECT: begin
                // A coin arriving with cancel is folded into the refund.
                if (cancel_req && (state == S_COLLECT)) begin
                    credit_nxt = sum;
                    state_nxt  = S_CHANGE;
                end else if (coin_ok) begin
                    credit_nxt = sum;
                    state_nxt  = (sum >= PRICE_C) ? S_VEND : S_COLLECT;
                end
            end
            S_VEND: begin
                credit_nxt = credit - PRICE_C;
                state_nxt  = (credit == PRICE_C) ? S_IDLE : S_CHANGE;
            end
            S_CHANGE: begin
                if (credit <= ONE_C) begin
                    credit_nxt = '0;
                    state_nxt  = S_IDLE;
                end else begin
                    credit_nxt = credit - ONE_C;
                end
            end
            default: begin
                credit_nxt = '0;
                state_nxt  = S_IDLE;
            end
        endcase
    end

    // State, credit and outputs registered together; outputs follow the new state.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state         <= S_IDLE;
            credit        <= '0;
            bus.coin_rdy  <= 1'b1;
            bus.vend      <= 1'b0;
            bus.chg_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            credit        <= credit_nxt;
            bus.coin_rdy  <= (state_nxt == S_IDLE) || (state_nxt == S_COLLECT);
            bus.vend      <= (state_nxt == S_VEND);
            bus.chg_pulse <= (state_nxt == S_CHANGE);
        end
    end

    assign bus.credit = credit;

endmodule
